// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Owns the single write/read port of the text video memory and shares it
//   between the text editor (port A), an auxiliary writer (port B) and a
//   built-in fill engine used for clear-screen / attribute fills. Everything
//   goes through one FSM so the memory only ever sees one master.
//
// Ports
//   sys_clk, rst_n               clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    port A request, held stable until a_ack
//   a_ack, a_rdata               port A completion pulse, read data
//   b_*                          same as port A, for port B
//   fill_start, fill_word        fill request pulse and fill value
//   fill_busy, fill_done         fill engine owns the port / last write done
//   mem_addr, mem_data, we       registered memory port
//   ret_data                     memory read data, READ_LAT cycles after addr
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 16,
  parameter int READ_LAT = 1,
  parameter int FILL_LEN = 2000
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_word,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          we,
  input  logic [DW-1:0] ret_data
);

  localparam int            CW        = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT  = CW'(READ_LAT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FILL_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FILL} state_t;

  state_t        r_state,     w_state;
  logic [AW-1:0] r_mem_addr,  w_mem_addr;
  logic [DW-1:0] r_mem_data,  w_mem_data;
  logic          r_we,        w_we;
  logic          r_a_ack,     w_a_ack;
  logic          r_b_ack,     w_b_ack;
  logic [DW-1:0] r_a_rdata,   w_a_rdata;
  logic [DW-1:0] r_b_rdata,   w_b_rdata;
  logic          r_fill_busy, w_fill_busy;
  logic          r_fill_done, w_fill_done;
  logic          r_fill_pend, w_fill_pend;
  logic [DW-1:0] r_fill_word, w_fill_word;
  logic          r_last_b,    w_last_b;
  logic          r_cur_b,     w_cur_b;
  logic [CW-1:0] r_cnt,       w_cnt;

  logic          w_a_elig;
  logic          w_b_elig;
  logic          w_grant_b;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // A port whose ack is showing this cycle still has its old request on the
  // wires, so it is not eligible again until the ack has gone.
  assign w_a_elig  = a_req & ~r_a_ack;
  assign w_b_elig  = b_req & ~r_b_ack;
  // r_last_b remembers the previous grant; on a tie the other port wins.
  assign w_grant_b = w_b_elig & (~w_a_elig | ~r_last_b);

  assign w_sel_we    = w_grant_b ? b_we    : a_we;
  assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;

  // Next-state and next-output logic for the single serialising FSM.
  always_comb begin
    w_state     = r_state;
    w_mem_addr  = r_mem_addr;
    w_mem_data  = r_mem_data;
    w_we        = r_we;
    w_a_ack     = 1'b0;
    w_b_ack     = 1'b0;
    w_a_rdata   = r_a_rdata;
    w_b_rdata   = r_b_rdata;
    w_fill_busy = r_fill_busy;
    w_fill_done = 1'b0;
    w_fill_pend = r_fill_pend;
    w_fill_word = r_fill_word;
    w_last_b    = r_last_b;
    w_cur_b     = r_cur_b;
    w_cnt       = r_cnt;

    // A fill asked for while a port transaction is in flight is parked until
    // the port is free; one asked for while the engine already runs is dropped.
    if (fill_start && !r_fill_busy && !r_fill_pend && (r_state != S_IDLE)) begin
      w_fill_pend = 1'b1;
      w_fill_word = fill_word;
    end

    case (r_state)
      S_IDLE: begin
        if (r_fill_pend || fill_start) begin
          w_fill_word = r_fill_pend ? r_fill_word : fill_word;
          w_fill_pend = 1'b0;
          w_fill_busy = 1'b1;
          w_we        = 1'b1;
          w_mem_addr  = '0;
          w_mem_data  = w_fill_word;
          w_state     = S_FILL;
        end else if (w_a_elig || w_b_elig) begin
          w_last_b   = w_grant_b;
          w_cur_b    = w_grant_b;
          w_mem_addr = w_sel_addr;
          if (w_sel_we) begin
            w_mem_data = w_sel_wdata;
            w_we       = 1'b1;
            w_state    = S_WR;
          end else begin
            w_we    = 1'b0;
            w_cnt   = LAT_INIT;
            w_state = S_RD;
          end
        end
      end
      S_WR: begin
        w_we    = 1'b0;
        w_a_ack = ~r_cur_b;
        w_b_ack = r_cur_b;
        w_state = S_IDLE;
      end
      S_RD: begin
        if (r_cnt == CNT_ONE) begin
          if (r_cur_b) begin
            w_b_rdata = ret_data;
            w_b_ack   = 1'b1;
          end else begin
            w_a_rdata = ret_data;
            w_a_ack   = 1'b1;
          end
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end
      S_FILL: begin
        if (r_mem_addr == LAST_ADDR) begin
          w_we        = 1'b0;
          w_fill_busy = 1'b0;
          w_fill_done = 1'b1;
          w_state     = S_IDLE;
        end else begin
          w_mem_addr = r_mem_addr + AW'(1);
        end
      end
      default: begin
        w_we    = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts whatever is in flight.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_we        <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_fill_busy <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_pend <= 1'b0;
      r_fill_word <= '0;
      r_last_b    <= 1'b1;
      r_cur_b     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_mem_addr  <= w_mem_addr;
      r_mem_data  <= w_mem_data;
      r_we        <= w_we;
      r_a_ack     <= w_a_ack;
      r_b_ack     <= w_b_ack;
      r_a_rdata   <= w_a_rdata;
      r_b_rdata   <= w_b_rdata;
      r_fill_busy <= w_fill_busy;
      r_fill_done <= w_fill_done;
      r_fill_pend <= w_fill_pend;
      r_fill_word <= w_fill_word;
      r_last_b    <= w_last_b;
      r_cur_b     <= w_cur_b;
      r_cnt       <= w_cnt;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign we        = r_we;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign fill_busy = r_fill_busy;
  assign fill_done = r_fill_done;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//   Bench for vram_arbiter: a word-array memory behind the DUT, directed
//   scenarios for writes, reads, round-robin, fills and reset, then random
//   traffic on both ports checked against a reference memory image that is
//   updated whenever a transaction or fill is reported complete.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int AW        = 11;
  localparam int DW        = 16;
  localparam int READ_LAT  = 1;
  localparam int FILL_LEN  = 2000;
  localparam int DEPTH     = 2048;
  localparam int ACK_LIMIT = 5000;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          fill_start;
  logic [DW-1:0] fill_word;
  logic          fill_busy, fill_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          we;
  logic [DW-1:0] ret_data;

  logic [DW-1:0] memArr [DEPTH];
  logic [DW-1:0] refMem [DEPTH];
  bit            memInit = 1'b0;

  int            totalChecks = 0;
  int            badChecks   = 0;
  int            negCount = 0, weCount = 0, aAckCount = 0, bAckCount = 0, doneCount = 0;
  int            lastBAckCyc = 0, lastDoneCyc = 0, curRun = 0, maxRun = 0;
  logic [AW-1:0] lastWeAddr = '0;
  logic [DW-1:0] lastWeData = '0;
  logic [AW-1:0] weLog [$];
  bit            logWe = 1'b0;
  bit            aPending = 1'b0, bPending = 1'b0;
  bit            modelOn = 1'b0, fillOutstanding = 1'b0;
  logic [DW-1:0] modelFillWord = '0;

  vram_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT), .FILL_LEN(FILL_LEN)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .fill_start(fill_start), .fill_word(fill_word), .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .we(we), .ret_data(ret_data)
  );

  // 100 MHz-style free-running clock.
  always #5 sys_clk = ~sys_clk;

  function automatic logic [DW-1:0] initVal(input int i);
    if (i == 16) return 16'hBEEF;
    return DW'(i * 37) ^ 16'hC3A5;
  endfunction

  // Memory with one cycle read latency: address registered by the DUT, data
  // returned combinationally from the array. First edge loads a known image.
  always @(posedge sys_clk) begin
    if (!memInit) begin
      for (int i = 0; i < DEPTH; i++) memArr[i] <= initVal(i);
      memInit <= 1'b1;
    end else if (we) begin
      memArr[mem_addr] <= mem_data;
    end
  end
  assign ret_data = memArr[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle observer: counts write strobes and pulses, checks that pulses
  // never overlap and only answer an outstanding request, and applies fills
  // to the reference image when the engine reports completion.
  always @(negedge sys_clk) begin
    negCount++;
    if (we) begin
      weCount++;
      curRun++;
      lastWeAddr = mem_addr;
      lastWeData = mem_data;
      if (logWe) weLog.push_back(mem_addr);
    end else begin
      curRun = 0;
    end
    if (curRun > maxRun) maxRun = curRun;
    if (a_ack | b_ack | fill_done)
      checkOutput("pulseExcl", 32'($countones({a_ack, b_ack, fill_done})), 32'd1);
    if (a_ack) begin
      aAckCount++;
      checkOutput("aAckOwned", 32'(aPending), 32'd1);
    end
    if (b_ack) begin
      bAckCount++;
      lastBAckCyc = negCount;
      checkOutput("bAckOwned", 32'(bPending), 32'd1);
    end
    if (fill_done) begin
      doneCount++;
      lastDoneCyc = negCount;
      if (modelOn) begin
        checkOutput("fillExpected", 32'(fillOutstanding), 32'd1);
        for (int i = 0; i < FILL_LEN; i++) refMem[i] = modelFillWord;
        fillOutstanding = 1'b0;
      end
    end
  end

  // Issue one transaction on a port and wait (bounded) for its ack.
  task automatic applyStimulus(input bit isB, input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                               output int lat);
    bit seen = 1'b0;
    lat = 0;
    if (isB) begin
      b_req = 1'b1; b_we = wr; b_addr = addr; b_wdata = wdata; bPending = 1'b1;
    end else begin
      a_req = 1'b1; a_we = wr; a_addr = addr; a_wdata = wdata; aPending = 1'b1;
    end
    while (!seen && lat < ACK_LIMIT) begin
      @(negedge sys_clk); #1;
      lat++;
      seen = isB ? b_ack : a_ack;
    end
    if (!seen) checkOutput(isB ? "bAckTimeout" : "aAckTimeout", 32'd0, 32'd1);
    rdata = isB ? b_rdata : a_rdata;
    if (isB) begin
      b_req = 1'b0; bPending = 1'b0;
    end else begin
      a_req = 1'b0; aPending = 1'b0;
    end
  endtask

  task automatic runPort(input bit isB, input int n);
    logic [DW-1:0] rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            wr;
    int            lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(negedge sys_clk); #1; end
      wr   = 1'($urandom_range(0, 1));
      addr = AW'(1984 + $urandom_range(0, 63));
      wd   = DW'($urandom);
      applyStimulus(isB, wr, addr, wd, rd, lat);
      if (wr) refMem[addr] = wd;
      else checkOutput(isB ? "bReadData" : "aReadData", 32'(rd), 32'(refMem[addr]));
    end
  endtask

  task automatic runFills(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(150, 400)) begin @(negedge sys_clk); #1; end
      modelFillWord   = DW'($urandom);
      fill_word       = modelFillWord;
      fillOutstanding = 1'b1;
      fill_start      = 1'b1;
      @(negedge sys_clk); #1;
      fill_start = 1'b0;
      w = 0;
      while (fillOutstanding && w < ACK_LIMIT) begin
        @(negedge sys_clk); #1;
        w++;
      end
      if (fillOutstanding) begin
        checkOutput("fillTimeout", 32'd0, 32'd1);
        fillOutstanding = 1'b0;
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "MemAddr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "MemData"}, 32'(mem_data), 32'd0);
    checkOutput({tag, "We"}, 32'(we), 32'd0);
    checkOutput({tag, "Acks"}, 32'({a_ack, b_ack}), 32'd0);
    checkOutput({tag, "ARdata"}, 32'(a_rdata), 32'd0);
    checkOutput({tag, "BRdata"}, 32'(b_rdata), 32'd0);
    checkOutput({tag, "Fill"}, 32'({fill_busy, fill_done}), 32'd0);
  endtask

  // Single A write of 0x1F41 at 0x005: one strobe, ack after two edges.
  task automatic singleAWrite(input string tag);
    logic [DW-1:0] rd;
    int lat, w0, a0, b0;
    w0 = weCount; a0 = aAckCount; b0 = bAckCount;
    applyStimulus(1'b0, 1'b1, 11'h005, 16'h1F41, rd, lat);
    checkOutput({tag, "Lat"}, 32'(lat), 32'd2);
    checkOutput({tag, "WeCount"}, 32'(weCount - w0), 32'd1);
    checkOutput({tag, "WeAddr"}, 32'(lastWeAddr), 32'h005);
    checkOutput({tag, "WeData"}, 32'(lastWeData), 32'h1F41);
    repeat (2) begin @(negedge sys_clk); #1; end
    checkOutput({tag, "AAcks"}, 32'(aAckCount - a0), 32'd1);
    checkOutput({tag, "BAcks"}, 32'(bAckCount - b0), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [31:0]   got;
    int lat, w0, a0, b0, d0, n0, diffs;

    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    fill_start = 1'b0; fill_word = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    checkResetOutputs("rst");
    rst_n = 1'b1;
    @(negedge sys_clk); #1;

    $display("[TB] single A write");
    singleAWrite("t1");

    $display("[TB] single B read");
    w0 = weCount;
    applyStimulus(1'b1, 1'b0, 11'h010, 16'h0000, rd, lat);
    checkOutput("t2Lat", 32'(lat), 32'(READ_LAT + 1));
    checkOutput("t2Rdata", 32'(rd), 32'hBEEF);
    @(negedge sys_clk); #1;
    checkOutput("t2AckPulse", 32'(b_ack), 32'd0);
    checkOutput("t2NoWrite", 32'(weCount - w0), 32'd0);

    // B was granted last, so the tie goes to A first and then alternates.
    $display("[TB] simultaneous A/B writes");
    w0 = weCount; a0 = aAckCount; b0 = bAckCount;
    weLog.delete();
    logWe = 1'b1;
    fork
      begin
        logic [DW-1:0] rdA;
        int latA;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, AW'(256 + k), DW'(16'hA000 + k), rdA, latA);
      end
      begin
        logic [DW-1:0] rdB;
        int latB;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, AW'(512 + k), DW'(16'hB000 + k), rdB, latB);
      end
    join
    logWe = 1'b0;
    checkOutput("t3WeCount", 32'(weCount - w0), 32'd6);
    for (int k = 0; k < 6; k++) begin
      got = (k < weLog.size()) ? 32'(weLog[k]) : 32'hFFFF_FFFF;
      checkOutput("t3Order", got, (k % 2 == 0) ? 32'(256 + k / 2) : 32'(512 + k / 2));
    end
    checkOutput("t3AAcks", 32'(aAckCount - a0), 32'd3);
    checkOutput("t3BAcks", 32'(bAckCount - b0), 32'd3);
    checkOutput("t3BRdataHeld", 32'(b_rdata), 32'hBEEF);

    $display("[TB] fill 0x0720");
    w0 = weCount; d0 = doneCount; maxRun = 0;
    fill_word = 16'h0720; fill_start = 1'b1;
    @(negedge sys_clk); #1;
    fill_start = 1'b0;
    checkOutput("t4Busy", 32'(fill_busy), 32'd1);
    n0 = 0;
    while (doneCount == d0 && n0 < 2200) begin @(negedge sys_clk); #1; n0++; end
    checkOutput("t4DoneSeen", 32'(doneCount - d0), 32'd1);
    checkOutput("t4BusyLow", 32'(fill_busy), 32'd0);
    repeat (3) begin @(negedge sys_clk); #1; end
    checkOutput("t4DoneOnce", 32'(doneCount - d0), 32'd1);
    checkOutput("t4WeCount", 32'(weCount - w0), 32'(FILL_LEN));
    checkOutput("t4WeRun", 32'(maxRun), 32'(FILL_LEN));
    diffs = 0;
    for (int i = 0; i < FILL_LEN; i++) if (memArr[i] !== 16'h0720) diffs++;
    checkOutput("t4Filled", 32'(diffs), 32'd0);
    diffs = 0;
    for (int i = FILL_LEN; i < DEPTH; i++) if (memArr[i] !== initVal(i)) diffs++;
    checkOutput("t4Untouched", 32'(diffs), 32'd0);

    $display("[TB] fill requested during A read and during fill");
    w0 = weCount; d0 = doneCount; a0 = aAckCount;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h030; aPending = 1'b1;
    @(negedge sys_clk); #1;
    fill_word = 16'h1234; fill_start = 1'b1;
    @(negedge sys_clk); #1;
    fill_start = 1'b0;
    checkOutput("t5AAck", 32'(a_ack), 32'd1);
    checkOutput("t5ARdata", 32'(a_rdata), 32'h0720);
    a_req = 1'b0; aPending = 1'b0;
    @(negedge sys_clk); #1;
    checkOutput("t5FillBusy", 32'(fill_busy), 32'd1);
    repeat (700) @(negedge sys_clk);
    #1;
    fill_word = 16'hAAAA; fill_start = 1'b1;
    @(negedge sys_clk); #1;
    fill_start = 1'b0;
    applyStimulus(1'b1, 1'b1, 11'h7F0, 16'h5555, rd, lat);
    checkOutput("t5DoneCount", 32'(doneCount - d0), 32'd1);
    checkOutput("t5BAfterDone", 32'(lastBAckCyc - lastDoneCyc), 32'd2);
    checkOutput("t5WeCount", 32'(weCount - w0), 32'(FILL_LEN + 1));
    checkOutput("t5AAcks", 32'(aAckCount - a0), 32'd1);
    diffs = 0;
    for (int i = 0; i < FILL_LEN; i++) if (memArr[i] !== 16'h1234) diffs++;
    checkOutput("t5Filled", 32'(diffs), 32'd0);
    checkOutput("t5BWrite", 32'(memArr[11'h7F0]), 32'h5555);

    $display("[TB] reset during fill");
    fill_word = 16'h3C3C; fill_start = 1'b1;
    @(negedge sys_clk); #1;
    fill_start = 1'b0;
    repeat (700) @(negedge sys_clk);
    #1;
    checkOutput("t6MidFill", 32'(fill_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6WeAsync", 32'(we), 32'd0);
    checkOutput("t6BusyAsync", 32'(fill_busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    #1;
    rst_n = 1'b1;
    checkResetOutputs("t6Rst");
    w0 = weCount; d0 = doneCount;
    repeat (10) begin @(negedge sys_clk); #1; end
    checkOutput("t6NoDone", 32'(doneCount - d0), 32'd0);
    checkOutput("t6NoWrites", 32'(weCount - w0), 32'd0);
    checkOutput("t6Idle", 32'(fill_busy), 32'd0);
    singleAWrite("t6A");

    $display("[TB] random traffic");
    for (int i = 0; i < DEPTH; i++) refMem[i] = memArr[i];
    modelOn = 1'b1;
    fork
      runPort(1'b0, 150);
      runPort(1'b1, 150);
      runFills(2);
    join
    repeat (4) begin @(negedge sys_clk); #1; end
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (memArr[i] !== refMem[i]) diffs++;
    checkOutput("memFinal", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
